apb_master_bridge: RTL

Upstream APB requester that drives the APB slave port. It accepts read and write commands on a valid/ready channel and buffers them in a small FIFO. Each command is issued as one APB SETUP/ACCESS transfer, and the write acknowledgement or read data comes back on a valid/ready response channel. One transfer is outstanding at a time.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_cmd_fifo.sv | 45 ++++
 rtl/apb_master_bridge.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB master bridge.
package apb_pkg;

    localparam int APB_DW             = 32;
    localparam int APB_AW             = 32;
    localparam int APB_FIFO_DEPTH     = 4;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO of apb_cmd_t; read data is the head entry (show-ahead).
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int FIFO_DEPTH = APB_FIFO_DEPTH
) (
    input  logic     PCLK,
    input  logic     PRESETn,
    input  logic     push,
    input  apb_cmd_t wr_data,
    input  logic     pop,
    output apb_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    apb_cmd_t        mem [FIFO_DEPTH];
    logic   [PW:0]   wr_ptr;
    logic   [PW:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rd_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: buffered valid/ready commands issued as SETUP/ACCESS transfers.
// Optional ACCESS timeout enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DW         = APB_DW,
    parameter int AW         = APB_AW,
    parameter int FIFO_DEPTH = APB_FIFO_DEPTH
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
`endif
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    output logic          busy
);

    apb_state_e state, state_nxt;
    apb_cmd_t   fifo_in, fifo_out;
    logic       fifo_full, fifo_empty;
    logic       pop, done, timeout;

    assign fifo_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);
    assign rsp_write = PWRITE;

    apb_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (cmd_valid),
        .wr_data (fifo_in),
        .pop     (pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] access_cnt;

    // Counts ACCESS cycles; the last allowed cycle without PREADY aborts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            access_cnt <= '0;
        else if (state == SETUP)
            access_cnt <= '0;
        else if (state == ACCESS)
            access_cnt <= access_cnt + 1'b1;
    end

    assign timeout = (state == ACCESS) && !PREADY && (access_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                // Going straight to SETUP keeps a lingering PREADY away from ACCESS.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
        end else begin
            if (pop) begin
                PADDR  <= fifo_out.addr;
                PWRITE <= fifo_out.write;
                PWDATA <= fifo_out.write ? fifo_out.wdata : '0;
            end
            if (done)
                rsp_rdata <= (PWRITE || timeout) ? '0 : PRDATA;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            rsp_err <= 1'b0;
        else if (done)
            rsp_err <= timeout;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
